uart_tx_cfg: RTL
================

# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter with an internal transmit FIFO. It adds programmable baud divisor, parity (none/even/odd) and 1 or 2 stop bits over a fixed-format serialiser. It sits between a byte-stream producer (valid/ready) and the board TX pin, so bursts of words can be queued without stalling the producer.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per character, 5..9
- DEPTH, 16: FIFO entries, power of two, ≥2
- DIV_WIDTH, 16: width of the runtime divisor
- DEFAULT_DIV, 868: divisor loaded at reset (100 MHz / 115200)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous and active-high
- tx_data  in  DATA_WIDTH  word to send
- tx_valid  in  1  producer has a word
- tx_ready  out  1  FIFO can accept; equals !full
- cfg_div  in  DIV_WIDTH  clocks per bit
- cfg_parity  in  2  0 none, 1 even, 2 odd, 3 treated as none
- cfg_stop2  in  1  1 = two stop bits
- txd  out  1  serial line, idle high
- busy  out  1  frame in progress or FIFO non-empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: a word is written on every edge with tx_valid && tx_ready. No write when full. Words are never dropped or duplicated.
- Frame order: start bit (0), then DATA_WIDTH data bits LSB first, then the parity bit if enabled, then 1 or 2 stop bits (1).
- Parity: even → XOR of the data bits; odd → its inverse.
- FSM states (uart_pkg::tx_state_t): IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. This pops the head word and latches cfg_div, cfg_parity and cfg_stop2 into frame registers.
  - START → DATA after one bit period.
  - DATA → PARITY after bit DATA_WIDTH-1 if parity is enabled, otherwise → STOP.
  - PARITY → STOP.
  - STOP → IDLE after 1 or 2 bit periods.
  - Any illegal state → IDLE with txd=1.
- Config changes mid-frame have no effect until the next frame's pop.
- Bit period is the latched divisor. A divisor value below 2 is treated as 2. The bit counter is DIV_WIDTH wide, loads divisor-1 and counts down to 0.
- Back-to-back: if the FIFO is non-empty when the last stop-bit period ends, the next start bit begins on the following edge (STOP → IDLE → START costs one idle-high cycle). No extra inter-frame gap.
- Reset (any time, including mid-frame): FIFO emptied, state IDLE, config registers ← DEFAULT_DIV / none / 1 stop.
- Reset values of outputs: txd=1, tx_ready=1, busy=0, level=0.

## Timing
- Word accepted at edge k into an empty FIFO with the FSM in IDLE:
  - pop at edge k+1;
  - txd=0 from edge k+1;
  - level reads 1 only between edge k and edge k+1.
- Each bit holds txd for exactly div clocks.
- Frame length is (1 + DATA_WIDTH + P + S) × div clocks, where P∈{0,1} and S∈{1,2}.
- busy falls on the edge where the FSM leaves STOP with the FIFO empty.
- Simultaneous push and pop with the FIFO neither full nor empty: level unchanged.
- When full, tx_ready stays low until the pop edge and rises after it. There is no same-cycle full bypass.
- level updates on the write or pop edge.

## Structure
- Package uart_pkg: tx_state_t enum, parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD), localparam MIN_DIV=2.
- Sub-module uart_sync_fifo (DATA_WIDTH, DEPTH):
  - registered read, with full/empty/level outputs;
  - pointers one bit wider than the address for the full/empty distinction;
  - wrap-around at DEPTH.
- Top module: config latch, bit counter, bit index counter, parity accumulator, FSM.

## Test plan
- cfg_div=4, 8N1, push 0xA5:
  - txd bits 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, 40 clocks total;
  - busy high throughout, low at the end;
  - level back to 0.
- cfg_div=4, cfg_parity=1, push 0x07: parity bit 1, 44-clock frame. Repeat with cfg_parity=2: parity bit 0.
- cfg_div=16, DEPTH=4, tx_valid held high with words 0x01..0x08:
  - exactly 5 words accepted before tx_ready falls, with level=4;
  - all 8 words leave in order;
  - one idle-high cycle between consecutive frames.
- cfg_stop2=1, cfg_div=8, push 0xFF: stop level held 16 clocks. cfg_div changed to 3 mid-frame: current frame keeps 8, next frame uses 3.
- Reset asserted during DATA bit 3 of 0x55 with 3 words queued:
  - after the reset edge txd=1, level=0, busy=0, tx_ready=1;
  - no further frames emitted.
- cfg_div=0 and cfg_div=1, push 0x00: each bit lasts 2 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the runtime-configurable UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   localparam int MIN_DIV = 2;

   // The unused code 3 falls back to no parity.
   function automatic parity_t decode_parity(input logic [1:0] code);
      case (code)
         2'd1:    return PAR_EVEN;
         2'd2:    return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read data; pointers carry one extra wrap bit
// so that full and empty can be told apart when the addresses match.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic                  do_wr, do_rd;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = rd_data_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
      if (do_rd) begin
         rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a transmit FIFO; divisor, parity and stop-bit count
// are captured from the cfg inputs each time a word is popped.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 868
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic [DIV_WIDTH-1:0]    cfg_div,
   input  logic [1:0]              cfg_parity,
   input  logic                    cfg_stop2,
   output logic                    txd,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int                   IDX_W     = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
   localparam logic [DIV_WIDTH-1:0] MIN_DIV_V = DIV_WIDTH'(MIN_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] RST_DIV   =
      (DIV_WIDTH'(DEFAULT_DIV) < MIN_DIV_V) ? MIN_DIV_V : DIV_WIDTH'(DEFAULT_DIV);

   logic                  fifo_full, fifo_empty, pop;
   logic [DATA_WIDTH-1:0] fifo_rd_data;

   tx_state_t             state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  par_q, par_d;
   logic                  txd_q, txd_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   parity_t               parity_q, parity_d;
   logic                  stop2_q, stop2_d;

   logic [DIV_WIDTH-1:0]  cfg_div_eff;
   logic [DIV_WIDTH-1:0]  reload;
   logic                  bit_done;

   uart_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tx_valid),
      .wr_data (tx_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign cfg_div_eff = (cfg_div < MIN_DIV_V) ? MIN_DIV_V : cfg_div;
   assign reload      = div_q - ONE;
   assign bit_done    = (cnt_q == '0);

   assign tx_ready = !fifo_full;
   assign txd      = txd_q;
   assign busy     = (state_q != IDLE) || !fifo_empty;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      stop_cnt_d = stop_cnt_q;
      sh_d       = sh_q;
      par_d      = par_q;
      txd_d      = txd_q;
      div_d      = div_q;
      parity_d   = parity_q;
      stop2_d    = stop2_q;
      pop        = 1'b0;

      if (state_q != IDLE && !bit_done) begin
         cnt_d = cnt_q - ONE;
      end

      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               pop      = 1'b1;
               state_d  = START;
               txd_d    = 1'b0;
               div_d    = cfg_div_eff;
               parity_d = decode_parity(cfg_parity);
               stop2_d  = cfg_stop2;
               cnt_d    = cfg_div_eff - ONE;
            end
         end
         START: begin
            // The popped word became valid on the pop edge and stays put until the next pop.
            if (bit_done) begin
               state_d = DATA;
               txd_d   = fifo_rd_data[0];
               sh_d    = fifo_rd_data >> 1;
               par_d   = fifo_rd_data[0];
               idx_d   = '0;
               cnt_d   = reload;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d = reload;
               if (idx_q == LAST_IDX) begin
                  if (parity_q != PAR_NONE) begin
                     state_d = PARITY;
                     txd_d   = par_q ^ (parity_q == PAR_ODD);
                  end else begin
                     state_d    = STOP;
                     txd_d      = 1'b1;
                     stop_cnt_d = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  txd_d = sh_q[0];
                  par_d = par_q ^ sh_q[0];
                  sh_d  = sh_q >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_d    = STOP;
               txd_d      = 1'b1;
               stop_cnt_d = 1'b0;
               cnt_d      = reload;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
                  cnt_d      = reload;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         stop_cnt_q <= 1'b0;
         sh_q       <= '0;
         par_q      <= 1'b0;
         txd_q      <= 1'b1;
         div_q      <= RST_DIV;
         parity_q   <= PAR_NONE;
         stop2_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         stop_cnt_q <= stop_cnt_d;
         sh_q       <= sh_d;
         par_q      <= par_d;
         txd_q      <= txd_d;
         div_q      <= div_d;
         parity_q   <= parity_d;
         stop2_q    <= stop2_d;
      end
   end

endmodule
